// File: rtl/cp0_int_ctrl.sv
// cp0_int_ctrl: Coprocessor-0 interrupt/exception receiver.
// Holds SR, Cause, EPC and PRId. Decides each cycle whether the pipeline
// is diverted to the handler, serves mfc0/mtc0 and handles eret.
module cp0_int_ctrl #(
  parameter logic [31:0] PRID    = 32'h4D49_5053,
  parameter int          HWINT_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          A1,
  input  logic [4:0]          A2,
  input  logic [31:0]         DIn,
  input  logic                WE,
  input  logic [31:0]         PC,
  input  logic                BD,
  input  logic [4:0]          ExcCode,
  input  logic [HWINT_W-1:0]  HWInt,
  input  logic                EXLClr,
  output logic                IntReq,
  output logic [31:0]         EPC,
  output logic [31:0]         DOut
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // Architectural state
  logic [HWINT_W-1:0] r_im;
  logic               r_exl;
  logic               r_ie;
  logic               r_bd;
  logic [HWINT_W-1:0] r_ip;
  logic [4:0]         r_exccode;
  logic [31:0]        r_epc;

  logic               w_int_pend;
  logic               w_exc_pend;
  logic [31:0]        w_epc_raw;
  logic [31:0]        w_epc_entry;
  logic [31:0]        w_sr;
  logic [31:0]        w_cause;
  logic               w_wr_sr;
  logic               w_wr_epc;

  // Pending-request decode; EXL blocks both interrupts and exceptions
  always_comb begin
    w_int_pend = (|(HWInt & r_im)) & r_ie & ~r_exl;
    w_exc_pend = (ExcCode != 5'd0) & ~r_exl;
    IntReq     = w_int_pend | w_exc_pend;
  end

  // Return address for the handler: a delay-slot instruction restarts at its branch
  always_comb begin
    if (BD) begin
      w_epc_raw = PC - 32'd4;
    end else begin
      w_epc_raw = PC;
    end
    w_epc_entry = {w_epc_raw[31:2], 2'b00};
  end

  // mtc0 write strobes; a diverted instruction never commits its write
  always_comb begin
    w_wr_sr  = WE & ~IntReq & (A2 == REG_SR);
    w_wr_epc = WE & ~IntReq & (A2 == REG_EPC);
  end

  // Packed register views for mfc0
  always_comb begin
    w_sr    = {16'b0, r_im, 8'b0, r_exl, r_ie};
    w_cause = {r_bd, 15'b0, r_ip, 3'b0, r_exccode, 2'b0};
  end

  // mfc0 read mux; reflects stored values only, no write bypass
  always_comb begin
    case (A1)
      REG_SR:    DOut = w_sr;
      REG_CAUSE: DOut = w_cause;
      REG_EPC:   DOut = r_epc;
      REG_PRID:  DOut = PRID;
      default:   DOut = 32'd0;
    endcase
  end

  assign EPC = r_epc;

  // CP0 state update: exception entry, mtc0 writes, eret and IP sampling
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= '0;
      r_exccode <= 5'd0;
      r_epc     <= 32'd0;
    end else begin
      // IP is a one-cycle delayed view of the raw lines regardless of EXL
      r_ip <= HWInt;
      if (IntReq) begin
        r_exl     <= 1'b1;
        r_bd      <= BD;
        r_exccode <= w_int_pend ? 5'd0 : ExcCode;
        r_epc     <= w_epc_entry;
      end else begin
        if (w_wr_sr) begin
          r_im  <= DIn[15:10];
          r_ie  <= DIn[0];
          // eret overrides the EXL bit of a simultaneous SR write
          r_exl <= EXLClr ? 1'b0 : DIn[1];
        end else if (EXLClr) begin
          r_exl <= 1'b0;
        end else begin
          r_exl <= r_exl;
        end
        if (w_wr_epc) begin
          r_epc <= {DIn[31:2], 2'b00};
        end else begin
          r_epc <= r_epc;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// tb_cp0_int_ctrl: directed table-driven bench for cp0_int_ctrl.
module tb_cp0_int_ctrl;

  localparam logic [31:0] PRID = 32'h4D49_5053;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC;
  logic        BD;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] DOut;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        eret;
    logic        exp_req;
    logic [31:0] exp_dout;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t vecs[$];

  cp0_int_ctrl #(.PRID(PRID), .HWINT_W(6)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .PC(PC), .BD(BD), .ExcCode(ExcCode), .HWInt(HWInt), .EXLClr(EXLClr),
    .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] din,
                     input logic we, input logic [31:0] pc, input logic bd, input logic [4:0] exc,
                     input logic [5:0] hw, input logic eret, input logic exp_req,
                     input logic [31:0] exp_dout, input logic [31:0] exp_epc);
    vec_t v;
    v.a1 = a1; v.a2 = a2; v.din = din; v.we = we; v.pc = pc; v.bd = bd;
    v.exc = exc; v.hw = hw; v.eret = eret; v.exp_req = exp_req;
    v.exp_dout = exp_dout; v.exp_epc = exp_epc;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; WE = 1'b0; PC = 32'd0; BD = 1'b0;
    ExcCode = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
  endtask

  initial begin
    //  a1     a2     din            we    pc            bd    exc    hw       eret  req   dout           epc
    add(5'd12, 5'd0,  32'd0,         1'b0, 32'd0,        1'b0, 5'd0,  6'h00,   1'b0, 1'b0, 32'd0,         32'd0);          // reset SR
    add(5'd15, 5'd0,  32'd0,         1'b0, 32'd0,        1'b0, 5'd0,  6'h00,   1'b0, 1'b0, PRID,          32'd0);          // PRId
    add(5'd12, 5'd12, 32'h0000_0401, 1'b1, 32'd0,        1'b0, 5'd0,  6'h00,   1'b0, 1'b0, 32'd0,         32'd0);          // mtc0 SR
    add(5'd12, 5'd0,  32'd0,         1'b0, 32'h3000,     1'b0, 5'd0,  6'h01,   1'b0, 1'b1, 32'h0000_0401, 32'd0);          // irq taken
    add(5'd13, 5'd0,  32'd0,         1'b0, 32'd0,        1'b0, 5'd0,  6'h01,   1'b0, 1'b0, 32'h0000_0400, 32'h3000);       // EXL blocks
    add(5'd12, 5'd0,  32'd0,         1'b0, 32'd0,        1'b0, 5'd0,  6'h01,   1'b0, 1'b0, 32'h0000_0403, 32'h3000);
    add(5'd12, 5'd0,  32'd0,         1'b0, 32'd0,        1'b0, 5'd0,  6'h01,   1'b1, 1'b0, 32'h0000_0403, 32'h3000);       // eret
    add(5'd14, 5'd14, 32'h1234_5678, 1'b1, 32'h3010,     1'b0, 5'd0,  6'h01,   1'b0, 1'b1, 32'h3000,      32'h3000);       // refire, mtc0 dropped
    add(5'd14, 5'd0,  32'd0,         1'b0, 32'd0,        1'b0, 5'd0,  6'h00,   1'b0, 1'b0, 32'h3010,      32'h3010);
    add(5'd12, 5'd12, 32'h0000_0003, 1'b1, 32'd0,        1'b0, 5'd0,  6'h00,   1'b1, 1'b0, 32'h0000_0403, 32'h3010);       // SR write + eret
    add(5'd12, 5'd0,  32'd0,         1'b0, 32'd0,        1'b0, 5'd0,  6'h3F,   1'b0, 1'b0, 32'h0000_0001, 32'h3010);       // IM=0 masks all
    add(5'd13, 5'd0,  32'd0,         1'b0, 32'd0,        1'b0, 5'd0,  6'h3F,   1'b0, 1'b0, 32'h0000_FC00, 32'h3010);       // IP visible
    add(5'd14, 5'd14, 32'h1234_567B, 1'b1, 32'd0,        1'b0, 5'd0,  6'h00,   1'b0, 1'b0, 32'h3010,      32'h3010);       // mtc0 EPC
    add(5'd14, 5'd0,  32'd0,         1'b0, 32'd0,        1'b0, 5'd0,  6'h00,   1'b0, 1'b0, 32'h1234_5678, 32'h1234_5678);
    add(5'd13, 5'd13, 32'hFFFF_FFFF, 1'b1, 32'd0,        1'b0, 5'd0,  6'h00,   1'b0, 1'b0, 32'd0,         32'h1234_5678);  // Cause read-only
    add(5'd13, 5'd0,  32'd0,         1'b0, 32'd0,        1'b0, 5'd0,  6'h00,   1'b0, 1'b0, 32'd0,         32'h1234_5678);
    add(5'd12, 5'd12, 32'd0,         1'b1, 32'd0,        1'b0, 5'd0,  6'h00,   1'b0, 1'b0, 32'h0000_0001, 32'h1234_5678);  // SR=0
    add(5'd13, 5'd0,  32'd0,         1'b0, 32'h3008,     1'b1, 5'd4,  6'h00,   1'b0, 1'b1, 32'd0,         32'h1234_5678);  // exc in delay slot
    add(5'd13, 5'd0,  32'd0,         1'b0, 32'd0,        1'b0, 5'd0,  6'h00,   1'b0, 1'b0, 32'h8000_0010, 32'h3004);
    add(5'd12, 5'd0,  32'd0,         1'b0, 32'd0,        1'b0, 5'd0,  6'h00,   1'b0, 1'b0, 32'h0000_0002, 32'h3004);
    add(5'd13, 5'd0,  32'd0,         1'b0, 32'h5000,     1'b0, 5'd5,  6'h00,   1'b0, 1'b0, 32'h8000_0010, 32'h3004);       // exc blocked by EXL
    add(5'd12, 5'd0,  32'd0,         1'b0, 32'd0,        1'b0, 5'd0,  6'h00,   1'b1, 1'b0, 32'h0000_0002, 32'h3004);       // eret
    add(5'd12, 5'd12, 32'h0000_0401, 1'b1, 32'd0,        1'b0, 5'd0,  6'h00,   1'b0, 1'b0, 32'd0,         32'h3004);
    add(5'd12, 5'd0,  32'd0,         1'b0, 32'h4000,     1'b0, 5'd10, 6'h01,   1'b0, 1'b1, 32'h0000_0401, 32'h3004);       // irq beats exc
    add(5'd13, 5'd0,  32'd0,         1'b0, 32'd0,        1'b0, 5'd0,  6'h00,   1'b0, 1'b0, 32'h0000_0400, 32'h4000);
    add(5'd12, 5'd0,  32'd0,         1'b0, 32'd0,        1'b0, 5'd0,  6'h00,   1'b1, 1'b0, 32'h0000_0403, 32'h4000);       // eret
    add(5'd14, 5'd0,  32'd0,         1'b0, 32'd0,        1'b1, 5'd1,  6'h00,   1'b0, 1'b1, 32'h4000,      32'h4000);       // PC=0, BD=1
    add(5'd14, 5'd0,  32'd0,         1'b0, 32'd0,        1'b0, 5'd0,  6'h00,   1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);  // wrap
    add(5'd5,  5'd0,  32'd0,         1'b0, 32'd0,        1'b0, 5'd0,  6'h00,   1'b0, 1'b0, 32'd0,         32'hFFFF_FFFC);  // unimplemented
    add(5'd13, 5'd0,  32'd0,         1'b0, 32'd0,        1'b0, 5'd0,  6'h00,   1'b0, 1'b0, 32'h8000_0004, 32'hFFFF_FFFC);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      A1 = vecs[i].a1; A2 = vecs[i].a2; DIn = vecs[i].din; WE = vecs[i].we;
      PC = vecs[i].pc; BD = vecs[i].bd; ExcCode = vecs[i].exc; HWInt = vecs[i].hw;
      EXLClr = vecs[i].eret;
      #2;
      check($sformatf("v%0d IntReq", i), {31'd0, IntReq}, {31'd0, vecs[i].exp_req});
      check($sformatf("v%0d DOut", i), DOut, vecs[i].exp_dout);
      check($sformatf("v%0d EPC", i), EPC, vecs[i].exp_epc);
    end

    // Reset mid-run with EXL=1 and EPC=0x3010: state clears between edges
    @(negedge clk);
    idle_inputs();
    EXLClr = 1'b1;                       // leave the handler first
    @(negedge clk);
    idle_inputs();
    PC = 32'h3010; ExcCode = 5'd3;
    #2;
    check("seq1 entry IntReq", {31'd0, IntReq}, 32'd1);
    @(negedge clk);
    idle_inputs();
    HWInt = 6'h01;
    A1 = 5'd12;
    #1;
    check("seq1 pre SR", DOut, 32'h0000_0403);
    check("seq1 pre EPC", EPC, 32'h3010);
    #1;
    reset = 1'b1;
    #1;
    check("seq1 rst SR", DOut, 32'd0);
    A1 = 5'd13; #1;
    check("seq1 rst Cause", DOut, 32'd0);
    A1 = 5'd14; #1;
    check("seq1 rst EPC rd", DOut, 32'd0);
    check("seq1 rst EPC", EPC, 32'd0);
    check("seq1 rst IntReq", {31'd0, IntReq}, 32'd0);
    A1 = 5'd15; #1;
    check("seq1 rst PRId", DOut, PRID);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    HWInt = 6'h01;
    A1 = 5'd13;
    #2;
    check("seq1 post IntReq", {31'd0, IntReq}, 32'd0);
    @(negedge clk);
    #2;
    check("seq1 post IP", DOut, 32'h0000_0400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
